// File: rtl/sd_read_arbiter_if.sv
// Bundle of the requester-side and SD-controller-side signals around the
// block-read arbiter. The arbiter takes the slave view; the surrounding
// system (requesters plus SD controller) takes the master view.
interface sd_read_arbiter_if;
  logic          req0;
  logic          req1;
  logic [31:0]   addr0;
  logic [31:0]   addr1;
  logic          ack0;
  logic          ack1;
  logic          err0;
  logic          err1;
  logic [4095:0] read_data;
  logic          sd_rd_en;
  logic [31:0]   sd_addr;
  logic          sd_busy;
  logic [4095:0] sd_read_data;

  modport master (
    output req0, req1, addr0, addr1, sd_busy, sd_read_data,
    input  ack0, ack1, err0, err1, read_data, sd_rd_en, sd_addr
  );

  modport slave (
    input  req0, req1, addr0, addr1, sd_busy, sd_read_data,
    output ack0, ack1, err0, err1, read_data, sd_rd_en, sd_addr
  );
endinterface

// File: rtl/sd_read_arbiter.sv
// Two-way round-robin arbiter for the SD controller block-read port.
// Sequences the rd_en/busy handshake for the granted requester, pulses
// ack when the block is valid, and aborts with err if the controller
// stalls for TIMEOUT cycles in either the Issue or the Wait phase.
module sd_read_arbiter #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic              clock,
  input  logic              reset,
  sd_read_arbiter_if.slave  bus,
  output logic [15:0]       arbiter_state
);

  typedef enum logic [15:0] {
    IDLE  = 16'h0000,
    ISSUE = 16'h0001,
    WAIT  = 16'h0002,
    DONE  = 16'h0003,
    ERROR = 16'hFFFE
  } state_t;

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic [31:0] addr_reg;
  logic [31:0] timer;
  logic        pick;

  // Winner of the next arbitration: a lone requester wins, a tie goes to
  // whoever was not served last.
  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) pick = ~last_grant;
    else if (bus.req1)        pick = 1'b1;
  end

  // Arbitration and read-handshake sequencing with stall watchdog.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      addr_reg   <= '0;
      timer      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            grant    <= pick;
            addr_reg <= pick ? bus.addr1 : bus.addr0;
            timer    <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.sd_busy) begin
            timer <= '0;
            state <= WAIT;
          end else if (timer == TIMER_LAST) begin
            state <= ERROR;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        WAIT: begin
          if (!bus.sd_busy) begin
            state <= DONE;
          end else if (timer == TIMER_LAST) begin
            state <= ERROR;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        DONE, ERROR: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only, so reset drops rd_en at once.
  always_comb begin
    bus.sd_rd_en = 1'b0;
    bus.sd_addr  = '0;
    bus.ack0     = 1'b0;
    bus.ack1     = 1'b0;
    bus.err0     = 1'b0;
    bus.err1     = 1'b0;
    case (state)
      ISSUE, WAIT: begin
        bus.sd_rd_en = 1'b1;
        bus.sd_addr  = addr_reg;
      end
      DONE: begin
        bus.ack0 = ~grant;
        bus.ack1 = grant;
      end
      ERROR: begin
        bus.err0 = ~grant;
        bus.err1 = grant;
      end
      default: ;
    endcase
  end

  assign bus.read_data  = bus.sd_read_data;
  assign arbiter_state  = state;

endmodule

// File: doc/sd_read_arbiter.md
# sd_read_arbiter

Round-robin arbiter that shares the SD controller's block-read port between two requesters, e.g. the instruction-fetch path and the data-memory path. It grants one requester at a time, sequences the controller's `rd_en`/`busy` handshake for it, and returns a one-cycle acknowledge when the 4096-bit block is valid. It sits between the memory subsystem and the SD controller, replacing a single fixed driver of that port. It adds a watchdog that reports an error if the controller stalls.

## Interface
- `TIMEOUT`, default 100000: maximum cycles spent in Issue or Wait before aborting. Legal range is 1 to 2^32-1.
- `clock` input 1: system clock. All flops update on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req0`, `req1` input 1 each: request level. Hold high until `ack`/`err` of the same index.
- `addr0`, `addr1` input 32 each: SD block address. Sampled only at grant.
- `ack0`, `ack1` output 1 each: one-cycle pulse; `read_data` is valid in that cycle.
- `err0`, `err1` output 1 each: one-cycle pulse; the transaction was aborted by timeout.
- `read_data` output 4096: pass-through of `sd_read_data`. The controller holds it stable until the next read.
- `sd_rd_en` output 1: read enable to the SD controller.
- `sd_addr` output 32: block address to the SD controller.
- `sd_busy` input 1: controller busy flag.
- `sd_read_data` input 4096: block data from the controller.
- `arbiter_state` output 16: current state encoding, for debug.

## Operation
- Registers: `state`, `grant` (1 bit), `last_grant` (1 bit), `addr_reg` (32), `timer` (32).
- Reset values:
  - `state` = Idle, `grant` = 0, `last_grant` = 1 (so `req0` wins the first tie), `addr_reg` = 0, `timer` = 0.
  - All outputs are 0, except `read_data`, which follows `sd_read_data`.
- Idle (16'h0000):
  - Outputs idle.
  - If only one request is high, grant that index.
  - If both are high, grant `!last_grant`.
  - On grant, latch `grant` and `addr_reg` from the granted `addrN`, clear `timer`, and go to Issue. With no requests, stay in Idle.
- Issue (16'h0001):
  - Drive `sd_rd_en` = 1 and `sd_addr` = `addr_reg`.
  - If `sd_busy` = 1, clear `timer` and go to Wait.
  - Else, if `timer` == TIMEOUT-1, go to Error. Otherwise increment `timer`.
- Wait (16'h0002):
  - Drive `sd_rd_en` = 1 and `sd_addr` = `addr_reg`.
  - If `sd_busy` = 0, go to Done.
  - Else, if `timer` == TIMEOUT-1, go to Error. Otherwise increment `timer`.
- Done (16'h0003):
  - Assert `ack[grant]` = 1.
  - Set `last_grant` <= `grant` and go to Idle.
- Error (16'hFFFE):
  - Assert `err[grant]` = 1 and `sd_rd_en` = 0.
  - Set `last_grant` <= `grant` and go to Idle.
- Unused encodings go to Idle.
- `sd_addr` = 0 whenever `sd_rd_en` = 0.
- Deasserting the granted `req` mid-transaction does not abort it; `ack`/`err` still pulses.
- The non-granted request waits, with no starvation: after any completion or error, a pending other requester wins the next arbitration.
- Changes to `addrN` after grant are ignored.

## Timing
- All outputs are combinational decodes of the registered state and registers. There is no input-to-output combinational path, except `read_data`.
- Grant latency:
  - `req` high in Idle at edge n: Issue from cycle n+1, and `sd_rd_en` rises in cycle n+1.
  - `sd_busy` seen high at edge m: Wait from cycle m+1.
  - `sd_busy` seen low in Wait at edge p: Done in cycle p+1 with the `ack` pulse; Idle in cycle p+2.
- Minimum turnaround between successive grants is 1 Idle cycle. Back-to-back grants are never made without passing Idle.
- Timeout: exactly TIMEOUT cycles in Issue (or in Wait) before Error.
  - With TIMEOUT = 1, a single cycle without a `sd_busy` transition triggers the abort.
- Reset asserted mid-operation: every register returns to its reset value immediately. `sd_rd_en` drops asynchronously, and no `ack`/`err` is generated.
- Simultaneous requests at reset release: `req0` is served first, then `req1`.

## Test plan
- Single read: `req0` = 1, `addr0` = 32'h2; controller raises busy 3 cycles after `sd_rd_en`, holds it 10 cycles, and returns a known block -> `sd_addr` = 2 while enabled; `ack0` pulses once, with `read_data` equal to the block in that cycle; `ack1`/`err*` stay 0.
- Contention: `req0` and `req1` both high from reset with addresses 0 and 1 -> `req0` is served first, then `req1`. Repeat with both held high -> grants alternate 0,1,0,1.
- Timeout: TIMEOUT = 8, `req1` high, `sd_busy` tied low -> exactly 8 cycles with `sd_rd_en` = 1, then an `err1` pulse with `sd_rd_en` = 0; `arbiter_state` passes through 16'hFFFE, then 16'h0000.
- Wait timeout: TIMEOUT = 8, busy rises, then sticks high -> `err` pulses after 8 Wait cycles; a subsequent normal read succeeds.
- Reset mid-Wait: `reset` driven low while in Wait -> `sd_rd_en` = 0 and `arbiter_state` = 0 without waiting for a clock edge; no `ack`; after release the same request is re-served and acknowledged.
- Request drop: `req0` deasserted during Wait, and `addr0` changed after grant -> `ack0` still pulses, and `sd_addr` keeps the originally latched address.
